// File: rtl/interpolation_row_feeder_pkg.sv
// Shared definitions for the interpolation row feeder: FSM state encoding,
// default pixel geometry (shared with the interpolation top) and helpers
// that derive counter and pointer widths from ROWS and FIFO_DEPTH.
package interpolation_row_feeder_pkg;

  localparam int unsigned DEF_DATAWIDTH  = 8;
  localparam int unsigned DEF_NPIX       = 16;
  localparam int unsigned DEF_ROWS       = 16;
  localparam int unsigned DEF_ADDRWIDTH  = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } feeder_state_e;

  // Width able to hold every value 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index into a power-of-two sized buffer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/interpolation_row_feeder_if.sv
// Memory-read and row-stream signals of the interpolation row feeder.
// master: the feeder; slave: reference memory arbiter plus interpolation top.
interface interpolation_row_feeder_if
  import interpolation_row_feeder_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned NPIX      = DEF_NPIX
);

  logic                      mem_req;
  logic [ADDRWIDTH-1:0]      mem_addr;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [NPIX*DATAWIDTH-1:0] mem_rdata;

  logic                      row_valid;
  logic                      row_ready;
  logic [NPIX*DATAWIDTH-1:0] row_data;
  logic                      row_last;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    output row_valid,
    input  row_ready,
    output row_data,
    output row_last
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    input  row_valid,
    output row_ready,
    input  row_data,
    input  row_last
  );

endinterface

// File: rtl/interpolation_row_feeder_fifo.sv
// feeder_row_fifo: synchronous show-ahead row buffer. The head entry is read
// straight out of the storage registers, so a push into an empty buffer is
// visible on the cycle after the write. Push and pop may coincide at any
// occupancy; a pop on empty is ignored, a push on full only lands with a pop.
module feeder_row_fifo
  import interpolation_row_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_NPIX * DEF_DATAWIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/interpolation_row_feeder.sv
// interpolation_row_feeder: fetches ROWS reference-window rows (base_addr,
// base_addr+stride, ...) from the reference memory and streams them, one row
// per transfer, into the FME interpolation datapath through a small FIFO.
// Optional build macro FEEDER_FRAME_CLAMP_EN adds frame_last_addr: every row
// address above it is replaced by it (bottom-row vertical padding).
module interpolation_row_feeder
  import interpolation_row_feeder_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DEF_DATAWIDTH,
  parameter int unsigned NPIX       = DEF_NPIX,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDRWIDTH-1:0]   base_addr,
  input  logic [ADDRWIDTH-1:0]   stride,
`ifdef FEEDER_FRAME_CLAMP_EN
  input  logic [ADDRWIDTH-1:0]   frame_last_addr,
`endif
  output logic                   busy,
  output logic                   done,
  interpolation_row_feeder_if.master bus
);

  localparam int unsigned ROW_W  = NPIX * DATAWIDTH;
  localparam int unsigned CNT_W  = cnt_width(ROWS);
  localparam int unsigned FCNT_W = cnt_width(FIFO_DEPTH);
  localparam int unsigned CRED_W = FCNT_W + 1;

  feeder_state_e        state_q;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     sent_q, sent_d;
  logic [FCNT_W-1:0]    inflight_q, inflight_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [ADDRWIDTH-1:0] stride_q;
  logic [ADDRWIDTH-1:0] addr_eff;

  logic                 req_c;
  logic                 grant;
  logic                 ret;
  logic                 xfer;
  logic [CRED_W-1:0]    credit;

  logic [ROW_W-1:0]     fifo_head;
  logic                 fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;

  // Rows either buffered or still owed by memory; bounds issue so the FIFO
  // can never overflow.
  assign credit = CRED_W'(fifo_count) + CRED_W'(inflight_q);

  assign req_c = (state_q == S_FETCH) && (issued_q < CNT_W'(ROWS)) &&
                 (credit < CRED_W'(FIFO_DEPTH));
  assign grant = req_c && bus.mem_gnt;
  assign ret   = bus.mem_rvalid && (inflight_q != '0);
  assign xfer  = bus.row_valid && bus.row_ready;

`ifdef FEEDER_FRAME_CLAMP_EN
  logic [ADDRWIDTH-1:0] clamp_q;

  // Frame-bottom clamp, applied to the already wrapped address.
  assign addr_eff = (addr_q > clamp_q) ? clamp_q : addr_q;
`else
  assign addr_eff = addr_q;
`endif

  assign bus.mem_req  = req_c;
  assign bus.mem_addr = req_c ? addr_eff : '0;

  // Next values of the issue/return/transfer counters and the row address.
  // The address accumulates stride per grant instead of multiplying.
  always_comb begin
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = inflight_q;
    addr_d     = addr_q;
    if ((state_q == S_IDLE) && start) begin
      issued_d = '0;
      sent_d   = '0;
      addr_d   = base_addr;
    end else begin
      if (grant) begin
        issued_d = issued_q + CNT_W'(1);
        addr_d   = addr_q + stride_q;
      end
      if (xfer) sent_d = sent_q + CNT_W'(1);
    end
    case ({grant, ret})
      2'b10:   inflight_d = inflight_q + FCNT_W'(1);
      2'b01:   inflight_d = inflight_q - FCNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Counter and address registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= '0;
      addr_q     <= '0;
    end else begin
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
    end
  end

  // Window control FSM; captures the window geometry when start is accepted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      stride_q <= '0;
`ifdef FEEDER_FRAME_CLAMP_EN
      clamp_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_FETCH;
            stride_q <= stride;
`ifdef FEEDER_FRAME_CLAMP_EN
            clamp_q  <= frame_last_addr;
`endif
          end
        end
        S_FETCH: begin
          if (issued_q == CNT_W'(ROWS)) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Leave on the edge of the final transfer so done follows it directly.
          if (sent_d == CNT_W'(ROWS)) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  feeder_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCNT_W)
  ) u_row_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (ret),
    .push_data_i (bus.mem_rdata),
    .pop_i       (xfer),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.row_valid = !fifo_empty;
  assign bus.row_data  = bus.row_valid ? fifo_head : '0;
  assign bus.row_last  = bus.row_valid && (sent_q == CNT_W'(ROWS - 1));

endmodule

// File: doc/interpolation_row_feeder.md
Name: interpolation_row_feeder

Overview:
- Streams one reference-window row per transfer into the FME interpolation datapath. Each row is NPIX pixels and drives in_0..in_15 of the interpolation top.
- Fetches ROWS rows from the reference-window memory, starting at base_addr and stepping by stride.
- Buffers fetched rows in a small FIFO so that memory stalls and interpolation backpressure are decoupled.
- Sits between the reference memory arbiter and the interpolation top. row_valid qualifies the interpolation enable.

Parameters:
DATAWIDTH, 8, bits per pixel
NPIX, 16, pixels per row (one per interpolation input)
ROWS, 16, rows per window
ADDRWIDTH, 16, memory row-address width
FIFO_DEPTH, 4, row buffer depth (power of 2, >=2)

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-low
start  in  1  one-cycle pulse; begins a window fetch; honoured only in IDLE
base_addr  in  ADDRWIDTH  address of row 0; sampled when start is accepted
stride  in  ADDRWIDTH  address step between rows; sampled when start is accepted
mem_req  out  1  read request
mem_addr  out  ADDRWIDTH  read row address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; returns in request order
mem_rdata  in  NPIX*DATAWIDTH  row data
row_valid  out  1  row available to interpolation
row_ready  in  1  interpolation accepts the row
row_data  out  NPIX*DATAWIDTH  pixel i at bits [i*DATAWIDTH +: DATAWIDTH]; maps to in_i
row_last  out  1  high with the ROWS-th row
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last row transfer

Behaviour:
- Reset (reset==0 at an edge): state IDLE; all outputs 0; FIFO empty; all counters 0. Reset mid-window aborts everything. mem_rvalid arriving after reset deasserts is discarded.
- States:
  - IDLE: start -> FETCH.
  - FETCH: when issued==ROWS -> DRAIN.
  - DRAIN: when sent==ROWS -> DONE.
  - DONE: pulses done for one cycle -> IDLE.
- busy=1 in FETCH, DRAIN and DONE. start outside IDLE is ignored.
- Issue rule: mem_req=1 in FETCH when issued<ROWS and fifo_count+inflight<FIFO_DEPTH.
  - mem_addr = base_addr + issued*stride, modulo 2^ADDRWIDTH (wrap-around permitted).
  - mem_req and mem_addr are held stable until mem_gnt. mem_gnt sampled while mem_req=0 is ignored.
- Counters (all registered):
  - issued increments on mem_req&mem_gnt.
  - inflight: +1 on grant, -1 on mem_rvalid; both in one cycle leaves it unchanged.
- mem_rvalid with inflight==0 is ignored.
- Every accepted return is pushed into the FIFO. The credit rule guarantees no overflow.
- Output handshake:
  - row_valid = FIFO not empty, show-ahead from a registered head.
  - Transfer on row_valid&row_ready.
  - row_data and row_last are held stable while row_valid&!row_ready.
- Simultaneous push and pop are allowed at any occupancy, including full and empty.
  - Push into an empty FIFO: row_valid is asserted the next cycle (no combinational rvalid->valid path).
- Latency with mem_gnt tied high, 1-cycle memory and row_ready tied high:
  - start accepted at cycle 0; first mem_req at cycle 1; first row_valid at cycle 3.
  - One row per cycle after that. done pulses at cycle 3+ROWS.
- row_last = row_valid & (sent==ROWS-1).
- sent increments on transfer.

Optional Feature:
- Macro: FEEDER_FRAME_CLAMP_EN.
- Defined:
  - Adds input frame_last_addr (ADDRWIDTH), sampled at start.
  - Each computed address above frame_last_addr is replaced by frame_last_addr. This replicates the bottom frame row as vertical padding.
  - Comparison is unsigned and applied after wrap-around.
- Undefined: port absent; addresses are used unmodified.

Decomposition:
- Shared package:
  - State encoding (IDLE/FETCH/DRAIN/DONE).
  - Row-count and FIFO-pointer widths derived with clog2 from ROWS and FIFO_DEPTH.
  - Default DATAWIDTH/NPIX constants, shared with the interpolation top.
- One sub-module, feeder_row_fifo: synchronous show-ahead FIFO, width NPIX*DATAWIDTH, depth FIFO_DEPTH, with count output.
  - Instantiated once; the control FSM and counters stay in the top.

Test Plan:
1. Basic stream: base_addr=0x0100, stride=0x0020, mem_gnt=1, 1-cycle memory, row_ready=1.
   - 16 requests at 0x0100..0x02E0, rows out in order, row_last on row 15, done at cycle 19.
2. Backpressure: row_ready low for 10 cycles after first row_valid.
   - Issue stalls at fifo_count+inflight==4; row_data held unchanged; no loss or duplication; total rows = 16.
3. Memory stall: mem_gnt low for 5 cycles on row 7.
   - mem_addr held at base+7*stride throughout; output order intact.
4. Wrap-around and ignored start: base_addr=0xFFF0, stride=0x0008.
   - Row 2 address 0x0000.
   - start pulsed during FETCH -> no effect; busy stays 1 until done.
5. Reset mid-window: reset=0 at row 9, including one rvalid landing in the reset cycle.
   - All outputs 0 next cycle; FIFO empty.
   - A fresh start then produces exactly 16 rows.
6. With FEEDER_FRAME_CLAMP_EN: frame_last_addr=0x0180, base_addr=0x0100, stride=0x0020.
   - Rows 4..15 all addressed at 0x0180.
